// File: rtl/atree_pkg.sv
// Shared constants and types for the adder tree and its downstream accumulator.
// The tree sum width sets the accumulator's default input width.
package atree_pkg;

  localparam int ATREE_IN_WIDTH  = 8;
  localparam int ATREE_LEVELS    = 2;
  localparam int ATREE_SUM_WIDTH = ATREE_IN_WIDTH + ATREE_LEVELS;

  typedef enum logic [0:0] {
    ACC_COLLECT = 1'b0,
    ACC_HOLD    = 1'b1
  } acc_state_t;

endpackage

// File: rtl/atree_accum_if.sv
// Beat input and result output handshakes of the accumulator, bundled for port use.
// The master side is the upstream/downstream environment; the slave side is the accumulator.
interface atree_accum_if #(
  parameter int IN_WIDTH  = 10,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_ovf;
  logic [CNT_WIDTH-1:0] out_beats;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_beats
  );
endinterface

// File: rtl/atree_accum_sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags when the true sum
// does not fit in WIDTH bits.
module sat_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH:0] full_s;

  // Widen by one bit so the carry out is the overflow indication.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b};
    ovf    = full_s[WIDTH];
    if (full_s[WIDTH]) begin
      sum = {WIDTH{1'b1}};
    end else begin
      sum = full_s[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/atree_accum.sv
// Packet accumulator behind the adder tree: folds beats into a saturating total
// and presents total, overflow flag and beat count on a valid/ready result port.
module atree_accum
  import atree_pkg::*;
#(
  parameter int IN_WIDTH  = ATREE_SUM_WIDTH,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_BEATS = 16,
  parameter int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  atree_accum_if.slave  bus
);

  acc_state_t           state_r;
  acc_state_t           state_nxt_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 final_s;

  logic [ACC_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 ovf_r;
  logic [ACC_WIDTH-1:0] ext_s;
  logic [ACC_WIDTH-1:0] sum_s;
  logic                 add_ovf_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic                 ovf_upd_s;

  logic                 out_valid_r;
  logic [ACC_WIDTH-1:0] out_data_r;
  logic                 out_ovf_r;
  logic [CNT_WIDTH-1:0] out_beats_r;

  assign ext_s = ACC_WIDTH'(bus.in_data);

  sat_add #(
    .WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .a   (acc_r),
    .b   (ext_s),
    .sum (sum_s),
    .ovf (add_ovf_s)
  );

  // Beat acceptance and packet-close detection; the count limit closes a packet
  // even without in_last, and both together still close it only once.
  always_comb begin
    accept_s  = bus.in_valid && (state_r == ACC_COLLECT);
    cnt_inc_s = cnt_r + CNT_WIDTH'(1);
    ovf_upd_s = ovf_r || add_ovf_s;
    final_s   = accept_s && (bus.in_last || (cnt_inc_s == CNT_WIDTH'(MAX_BEATS)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACC_COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; in_ready depends on the state alone.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    case (state_r)
      ACC_COLLECT: begin
        in_ready_s = 1'b1;
        if (final_s) begin
          state_nxt_s = ACC_HOLD;
        end else begin
          state_nxt_s = ACC_COLLECT;
        end
      end
      ACC_HOLD: begin
        in_ready_s = 1'b0;
        if (out_valid_r && bus.out_ready) begin
          state_nxt_s = ACC_COLLECT;
        end else begin
          state_nxt_s = ACC_HOLD;
        end
      end
      default: begin
        in_ready_s  = 1'b0;
        state_nxt_s = ACC_COLLECT;
      end
    endcase
  end

  // Running total, beat count and sticky overflow; cleared when a packet closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_WIDTH{1'b0}};
      cnt_r <= {CNT_WIDTH{1'b0}};
      ovf_r <= 1'b0;
    end else if (final_s) begin
      acc_r <= {ACC_WIDTH{1'b0}};
      cnt_r <= {CNT_WIDTH{1'b0}};
      ovf_r <= 1'b0;
    end else if (accept_s) begin
      acc_r <= sum_s;
      cnt_r <= cnt_inc_s;
      ovf_r <= ovf_upd_s;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
      ovf_r <= ovf_r;
    end
  end

  // Result registers: loaded on the closing beat, held until the handshake and
  // left at their last values afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {ACC_WIDTH{1'b0}};
      out_ovf_r   <= 1'b0;
      out_beats_r <= {CNT_WIDTH{1'b0}};
    end else if (final_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sum_s;
      out_ovf_r   <= ovf_upd_s;
      out_beats_r <= cnt_inc_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_beats = out_beats_r;

endmodule

// File: tb/tb_atree_accum.sv
// Bench for atree_accum: directed scenarios plus random packets, all results
// checked against an integer packet model and an expected-result queue.
module tb_atree_accum;

  localparam int IN_W  = 10;
  localparam int ACC_W = 11;
  localparam int MAXB  = 4;
  localparam int CNT_W = 3;
  localparam int SAT   = (1 << ACC_W) - 1;

  typedef struct {
    int data;
    int ovf;
    int beats;
  } result_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  result_t exp_q[$];
  int   m_sum;
  int   m_cnt;

  atree_accum_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .CNT_WIDTH(CNT_W)) bus ();

  atree_accum #(
    .IN_WIDTH  (IN_W),
    .ACC_WIDTH (ACC_W),
    .MAX_BEATS (MAXB),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Packet model: exact integer total, clamped at the end; overflow iff the
  // exact total exceeds the accumulator range.
  task automatic model_accept(input int d, input bit last);
    result_t r;
    m_sum += d;
    m_cnt++;
    if (last || m_cnt == MAXB) begin
      r.data  = (m_sum > SAT) ? SAT : m_sum;
      r.ovf   = (m_sum > SAT) ? 1 : 0;
      r.beats = m_cnt;
      exp_q.push_back(r);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input int d, input bit last, input bit rnd_ready);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(d);
    bus.in_last  = last;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    if (k >= 40) begin
      check("accept_timeout", 32'(k), 32'd0);
    end else begin
      model_accept(d, last);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Result monitor: compares each handshaken result with the model and checks
  // the held result does not change while stalled.
  bit      hold_pending;
  result_t held;
  always @(posedge clk) begin
    result_t e;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(held.data));
        check("hold_beats", 32'(bus.out_beats), 32'(held.beats));
      end
      if (bus.out_valid && bus.out_ready) begin
        hold_pending = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 32'(bus.out_data), 32'(e.data));
          check("res_ovf", 32'(bus.out_ovf), 32'(e.ovf));
          check("res_beats", 32'(bus.out_beats), 32'(e.beats));
        end
      end else if (bus.out_valid) begin
        hold_pending = 1'b1;
        held.data    = int'(bus.out_data);
        held.beats   = int'(bus.out_beats);
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    int len;
    int d;
    n_checks = 0;
    n_fail   = 0;
    m_sum    = 0;
    m_cnt    = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // 1. Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    check("rst_out_beats", 32'(bus.out_beats), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. Basic packet and one-cycle bubble
    send_beat(153, 1'b0, 1'b0);
    send_beat(100, 1'b0, 1'b0);
    send_beat(1020, 1'b1, 1'b0);
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic_data", 32'(bus.out_data), 32'd1273);
    check("basic_beats", 32'(bus.out_beats), 32'd3);
    check("basic_ovf", 32'(bus.out_ovf), 32'd0);
    check("basic_bubble", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("basic_ready_back", 32'(bus.in_ready), 32'd1);
    check("basic_valid_drop", 32'(bus.out_valid), 32'd0);
    check("basic_data_kept", 32'(bus.out_data), 32'd1273);

    // 3. Forced close at MAX_BEATS, next beat waits out the bubble
    for (int i = 0; i < MAXB; i++) send_beat(10, 1'b0, 1'b0);
    check("force_data", 32'(bus.out_data), 32'd40);
    check("force_beats", 32'(bus.out_beats), 32'd4);
    check("force_bubble", 32'(bus.in_ready), 32'd0);
    send_beat(10, 1'b1, 1'b0);
    check("force_next_data", 32'(bus.out_data), 32'd10);
    check("force_next_beats", 32'(bus.out_beats), 32'd1);

    // 4. Saturation, then a clean packet
    @(negedge clk);
    send_beat(1023, 1'b0, 1'b0);
    send_beat(1023, 1'b0, 1'b0);
    send_beat(5, 1'b1, 1'b0);
    check("sat_data", 32'(bus.out_data), 32'd2047);
    check("sat_ovf", 32'(bus.out_ovf), 32'd1);
    @(negedge clk);
    send_beat(3, 1'b1, 1'b0);
    check("sat_next_data", 32'(bus.out_data), 32'd3);
    check("sat_next_ovf", 32'(bus.out_ovf), 32'd0);

    // 5. Backpressure with beats offered during hold
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_beat(7, 1'b0, 1'b0);
    send_beat(9, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(99);
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data", 32'(bus.out_data), 32'd16);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);

    // 6. Mid-packet asynchronous reset
    send_beat(500, 1'b0, 1'b0);
    send_beat(600, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'd0);
    check("arst_out_ovf", 32'(bus.out_ovf), 32'd0);
    check("arst_out_beats", 32'(bus.out_beats), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(7, 1'b1, 1'b0);
    check("arst_next_data", 32'(bus.out_data), 32'd7);
    check("arst_next_beats", 32'(bus.out_beats), 32'd1);

    // Random packets with random backpressure
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(0, 1023));
        bus.out_ready = ($urandom_range(0, 3) != 0);
        send_beat(d, (i == len - 1), 1'b1);
      end
    end

    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
